lcd_ctrl_gen: RTL

- Parametrised successor image-window controller.
- Loads an IMG_W x IMG_H frame from IROM into an internal buffer.
- Applies host commands to a 2x2 operation window anchored at a movable operation point, then streams the frame to IRAM on WRITE.
- Adds over the previous generation:
  - generic frame size and pixel width;
  - RELOAD command;
  - repeatable WRITE;
  - defined no-op handling.

---
 rtl/lcd_ctrl_pkg.sv | 37 +++
 rtl/lcd_win_alu.sv | 77 +++++++
 rtl/lcd_ctrl_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg
// Shared definitions for the image-window controller: host command codes,
// the controller state encoding and a constant-evaluable ceil(log2) helper
// used to size address and coordinate fields.
package lcd_ctrl_pkg;

    // Host command codes (4-bit cmd port)
    localparam logic [3:0] CMD_WRITE    = 4'd0;
    localparam logic [3:0] CMD_UP       = 4'd1;
    localparam logic [3:0] CMD_DOWN     = 4'd2;
    localparam logic [3:0] CMD_LEFT     = 4'd3;
    localparam logic [3:0] CMD_RIGHT    = 4'd4;
    localparam logic [3:0] CMD_MAX      = 4'd5;
    localparam logic [3:0] CMD_MIN      = 4'd6;
    localparam logic [3:0] CMD_AVG      = 4'd7;
    localparam logic [3:0] CMD_CCW      = 4'd8;
    localparam logic [3:0] CMD_CW       = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y = 4'd11;
    localparam logic [3:0] CMD_RELOAD   = 4'd12;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        IDLE  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Smallest r with 2**r >= value
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu
// Purely combinational 2x2 window operator. Given the four window pixels
// (P0 top-left, P1 top-right, P2 bottom-left, P3 bottom-right) and a command
// code, produces the replacement pixels for the max/min/avg, rotate and
// mirror commands. Any other code passes the window through unchanged.
// Ports:
//   p0_i..p3_i  current window pixels
//   cmd_i       command code
//   n0_o..n3_o  new window pixels
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] p0_i,
    input  logic [PIX_W-1:0] p1_i,
    input  logic [PIX_W-1:0] p2_i,
    input  logic [PIX_W-1:0] p3_i,
    input  logic [3:0]       cmd_i,
    output logic [PIX_W-1:0] n0_o,
    output logic [PIX_W-1:0] n1_o,
    output logic [PIX_W-1:0] n2_o,
    output logic [PIX_W-1:0] n3_o
);

    logic [PIX_W-1:0] maxTop, maxBot, maxAll;
    logic [PIX_W-1:0] minTop, minBot, minAll;
    logic [PIX_W+1:0] sum;
    logic [PIX_W-1:0] avg;

    // Reductions over the window; the sum carries two extra bits so four
    // full-scale pixels cannot overflow before the divide-by-four.
    always_comb begin
        maxTop = (p0_i > p1_i) ? p0_i : p1_i;
        maxBot = (p2_i > p3_i) ? p2_i : p3_i;
        maxAll = (maxTop > maxBot) ? maxTop : maxBot;
        minTop = (p0_i < p1_i) ? p0_i : p1_i;
        minBot = (p2_i < p3_i) ? p2_i : p3_i;
        minAll = (minTop < minBot) ? minTop : minBot;
        sum    = {2'b00, p0_i} + {2'b00, p1_i} + {2'b00, p2_i} + {2'b00, p3_i};
        avg    = sum[PIX_W+1:2];
    end

    // Every output is derived from the pre-command inputs, so rotations and
    // swaps behave as a single parallel assignment.
    always_comb begin
        n0_o = p0_i;
        n1_o = p1_i;
        n2_o = p2_i;
        n3_o = p3_i;
        case (cmd_i)
            CMD_MAX: begin
                n0_o = maxAll; n1_o = maxAll; n2_o = maxAll; n3_o = maxAll;
            end
            CMD_MIN: begin
                n0_o = minAll; n1_o = minAll; n2_o = minAll; n3_o = minAll;
            end
            CMD_AVG: begin
                n0_o = avg; n1_o = avg; n2_o = avg; n3_o = avg;
            end
            CMD_CCW: begin
                n0_o = p1_i; n1_o = p3_i; n3_o = p2_i; n2_o = p0_i;
            end
            CMD_CW: begin
                n0_o = p2_i; n2_o = p3_i; n3_o = p1_i; n1_o = p0_i;
            end
            CMD_MIRROR_X: begin
                n0_o = p2_i; n2_o = p0_i; n1_o = p3_i; n3_o = p1_i;
            end
            CMD_MIRROR_Y: begin
                n0_o = p1_i; n1_o = p0_i; n2_o = p3_i; n3_o = p2_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// lcd_ctrl_gen
// Image-window controller. Loads an IMG_W x IMG_H frame from IROM into an
// internal buffer, applies host commands to a 2x2 window anchored at a
// movable operation point, and streams the whole buffer to IRAM on WRITE.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   cmd, cmd_valid      host command and strobe (taken only when busy=0)
//   IROM_Q              ROM data, one cycle after IROM_rd/IROM_A
//   IROM_rd, IROM_A     ROM read enable and address
//   IRAM_valid, IRAM_D, IRAM_A   RAM write strobe, data, address
//   busy                controller cannot take a command
//   done                last frame write finished (held until next command)
module lcd_ctrl_gen
    import lcd_ctrl_pkg::*;
#(
    parameter  int IMG_W = 8,
    parameter  int IMG_H = 8,
    parameter  int PIX_W = 8,
    localparam int N     = IMG_W * IMG_H,
    localparam int AW    = clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    input  logic [PIX_W-1:0] IROM_Q,
    output logic             IROM_rd,
    output logic [AW-1:0]    IROM_A,
    output logic             IRAM_valid,
    output logic [PIX_W-1:0] IRAM_D,
    output logic [AW-1:0]    IRAM_A,
    output logic             busy,
    output logic             done
);

    localparam int XW = clog2(IMG_W);
    localparam int YW = clog2(IMG_H);
    // One extra bit so the load counter can reach N+1 (two-cycle ROM tail)
    localparam int CW = AW + 1;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [XW-1:0]    px_q;
    logic [YW-1:0]    py_q;
    logic [3:0]       cmd_q;
    logic             iromRd_q;
    logic [AW-1:0]    iromA_q;
    logic             iramValid_q;
    logic [PIX_W-1:0] iramD_q;
    logic [AW-1:0]    iramA_q;
    logic             busy_q;
    logic             done_q;

    logic [PIX_W-1:0] buf_q [N];

    logic [AW-1:0]    a0, a1, a2, a3;
    logic [PIX_W-1:0] n0, n1, n2, n3;
    logic             ldWe;
    logic [AW-1:0]    ldAddr;
    logic             winWe;

    // Frame sizes are powers of two, so a row-major index is simply {y, x}.
    assign a0 = {py_q - YW'(1), px_q - XW'(1)};
    assign a1 = {py_q - YW'(1), px_q};
    assign a2 = {py_q, px_q - XW'(1)};
    assign a3 = {py_q, px_q};

    // ROM data lags its address by two edges (output register plus ROM
    // latency), so the capture address trails the load counter by two.
    assign ldWe   = (state_q == LOAD) && (cnt_q >= CW'(2)) && (cnt_q <= CW'(N + 1));
    assign ldAddr = AW'(cnt_q - CW'(2));
    assign winWe  = (state_q == EXEC) && (cmd_q >= CMD_MAX) && (cmd_q <= CMD_MIRROR_Y);

    lcd_win_alu #(
        .PIX_W (PIX_W)
    ) u_alu (
        .p0_i  (buf_q[a0]),
        .p1_i  (buf_q[a1]),
        .p2_i  (buf_q[a2]),
        .p3_i  (buf_q[a3]),
        .cmd_i (cmd_q),
        .n0_o  (n0),
        .n1_o  (n1),
        .n2_o  (n2),
        .n3_o  (n3)
    );

    // Frame buffer: no reset, contents are only meaningful after a load.
    always_ff @(posedge clk) begin
        if (ldWe) begin
            buf_q[ldAddr] <= IROM_Q;
        end
        if (winWe) begin
            buf_q[a0] <= n0;
            buf_q[a1] <= n1;
            buf_q[a2] <= n2;
            buf_q[a3] <= n3;
        end
    end

    // Controller FSM with registered interface outputs. The shared counter
    // walks ROM addresses in LOAD and RAM addresses in WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            px_q        <= XW'(IMG_W / 2);
            py_q        <= YW'(IMG_H / 2);
            cmd_q       <= '0;
            iromRd_q    <= 1'b0;
            iromA_q     <= '0;
            iramValid_q <= 1'b0;
            iramD_q     <= '0;
            iramA_q     <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (cnt_q < CW'(N)) begin
                        iromRd_q <= 1'b1;
                        iromA_q  <= cnt_q[AW-1:0];
                    end else begin
                        iromRd_q <= 1'b0;
                    end
                    if (cnt_q == CW'(N + 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                IDLE: begin
                    if (cmd_valid && !busy_q) begin
                        cmd_q   <= cmd;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    case (cmd_q)
                        CMD_WRITE: begin
                            state_q <= WRITE;
                            busy_q  <= 1'b1;
                        end
                        CMD_RELOAD: begin
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                        end
                        CMD_UP: begin
                            if (py_q > YW'(1)) py_q <= py_q - YW'(1);
                        end
                        CMD_DOWN: begin
                            if (py_q < YW'(IMG_H - 1)) py_q <= py_q + YW'(1);
                        end
                        CMD_LEFT: begin
                            if (px_q > XW'(1)) px_q <= px_q - XW'(1);
                        end
                        CMD_RIGHT: begin
                            if (px_q < XW'(IMG_W - 1)) px_q <= px_q + XW'(1);
                        end
                        default: ;
                    endcase
                end
                WRITE: begin
                    if (cnt_q < CW'(N)) begin
                        iramValid_q <= 1'b1;
                        iramA_q     <= cnt_q[AW-1:0];
                        iramD_q     <= buf_q[cnt_q[AW-1:0]];
                        cnt_q       <= cnt_q + CW'(1);
                    end else begin
                        iramValid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IROM_rd    = iromRd_q;
    assign IROM_A     = iromA_q;
    assign IRAM_valid = iramValid_q;
    assign IRAM_D     = iramD_q;
    assign IRAM_A     = iramA_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
